// File: rtl/term_writer.sv
// Terminal write engine: interprets a byte stream, writes the 80x25 circular character
// buffer and drives cursor position, cursor blink and scroll offset to the video generator.
module term_writer #(
   parameter int BLINK_FRAMES = 30,
   parameter int COLS         = 80,
   parameter int ROWS         = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   input  logic        vblank,
   output logic        wr_en,
   output logic [10:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic [10:0] first_char,
   output logic        cursor_blink_on
);

   localparam logic [10:0] BUF_SIZE     = 11'(COLS * ROWS);
   localparam logic [11:0] BUF_SIZE_12  = 12'(COLS * ROWS);
   localparam logic [10:0] LAST_ROW_ADR = 11'(COLS * (ROWS - 1));
   localparam logic [10:0] ROW_LEN      = 11'(COLS);
   localparam logic [6:0]  X_LAST       = 7'(COLS - 1);
   localparam logic [4:0]  Y_LAST       = 5'(ROWS - 1);
   localparam logic [7:0]  SPACE        = 8'h20;
   localparam logic [7:0]  CH_BS        = 8'h08;
   localparam logic [7:0]  CH_LF        = 8'h0A;
   localparam logic [7:0]  CH_FF        = 8'h0C;
   localparam logic [7:0]  CH_CR        = 8'h0D;
   localparam int          BW           = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      CLEAR_ALL  = 2'd0,
      IDLE       = 2'd1,
      WRITE      = 2'd2,
      CLEAR_LINE = 2'd3
   } state_t;

   // Row offset y*80 built from shifts; the sum never exceeds two buffer lengths.
   function automatic logic [10:0] screen_addr(input logic [10:0] base,
                                               input logic [4:0]  y,
                                               input logic [6:0]  x);
      logic [11:0] sum;
      sum = {1'b0, base} + {1'b0, y, 6'b000000} + {3'b000, y, 4'b0000} + {5'b00000, x};
      if (sum >= BUF_SIZE_12) begin
         sum = sum - BUF_SIZE_12;
      end else begin
         sum = sum;
      end
      return sum[10:0];
   endfunction

   state_t        state_r;
   logic [10:0]   clr_cnt_r;
   logic [10:0]   clr_addr_r;
   logic          wr_en_r;
   logic [10:0]   wr_addr_r;
   logic [7:0]    wr_data_r;
   logic [6:0]    cursor_x_r;
   logic [4:0]    cursor_y_r;
   logic [10:0]   first_char_r;
   logic          ready_r;
   logic          blink_r;
   logic [BW-1:0] blink_cnt_r;
   logic          vblank_prev_r;

   logic          accept_s;
   logic          printable_s;
   logic          vblank_rise_s;
   logic [10:0]   cur_addr_s;
   logic [10:0]   next_first_s;

   assign accept_s      = char_valid & ready_r;
   assign printable_s   = (char_in >= 8'h20) && (char_in <= 8'h7E);
   assign vblank_rise_s = vblank & ~vblank_prev_r;
   assign cur_addr_s    = screen_addr(first_char_r, cursor_y_r, cursor_x_r);
   assign next_first_s  = (first_char_r == LAST_ROW_ADR) ? 11'd0 : (first_char_r + ROW_LEN);

   // Main engine: decode, buffer writes, cursor and scroll bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= CLEAR_ALL;
         clr_cnt_r    <= 11'd0;
         clr_addr_r   <= 11'd0;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= 11'd0;
         wr_data_r    <= SPACE;
         cursor_x_r   <= 7'd0;
         cursor_y_r   <= 5'd0;
         first_char_r <= 11'd0;
         ready_r      <= 1'b0;
      end else begin
         case (state_r)
            CLEAR_ALL: begin
               if (clr_cnt_r == BUF_SIZE) begin
                  wr_en_r <= 1'b0;
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= clr_cnt_r;
                  wr_data_r <= SPACE;
                  clr_cnt_r <= clr_cnt_r + 11'd1;
               end
            end
            IDLE: begin
               wr_en_r <= 1'b0;
               if (accept_s && printable_s) begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= cur_addr_s;
                  wr_data_r <= char_in;
                  ready_r   <= 1'b0;
                  state_r   <= WRITE;
               end else if (accept_s) begin
                  case (char_in)
                     CH_CR: cursor_x_r <= 7'd0;
                     CH_BS: begin
                        if (cursor_x_r != 7'd0) begin
                           cursor_x_r <= cursor_x_r - 7'd1;
                        end else begin
                           cursor_x_r <= cursor_x_r;
                        end
                     end
                     CH_LF: begin
                        if (cursor_y_r != Y_LAST) begin
                           cursor_y_r <= cursor_y_r + 5'd1;
                        end else begin
                           // Scroll: blank the old top row, which becomes the new bottom row.
                           first_char_r <= next_first_s;
                           wr_en_r      <= 1'b1;
                           wr_addr_r    <= first_char_r;
                           wr_data_r    <= SPACE;
                           clr_addr_r   <= first_char_r + 11'd1;
                           clr_cnt_r    <= 11'd1;
                           ready_r      <= 1'b0;
                           state_r      <= CLEAR_LINE;
                        end
                     end
                     CH_FF: begin
                        // Address 0 is written on the accepting edge so the clear spans 2000 cycles.
                        first_char_r <= 11'd0;
                        cursor_x_r   <= 7'd0;
                        cursor_y_r   <= 5'd0;
                        wr_en_r      <= 1'b1;
                        wr_addr_r    <= 11'd0;
                        wr_data_r    <= SPACE;
                        clr_cnt_r    <= 11'd1;
                        ready_r      <= 1'b0;
                        state_r      <= CLEAR_ALL;
                     end
                     default: state_r <= IDLE;
                  endcase
               end else begin
                  state_r <= IDLE;
               end
            end
            WRITE: begin
               wr_en_r <= 1'b0;
               if (cursor_x_r != X_LAST) begin
                  cursor_x_r <= cursor_x_r + 7'd1;
                  ready_r    <= 1'b1;
                  state_r    <= IDLE;
               end else if (cursor_y_r != Y_LAST) begin
                  cursor_x_r <= 7'd0;
                  cursor_y_r <= cursor_y_r + 5'd1;
                  ready_r    <= 1'b1;
                  state_r    <= IDLE;
               end else begin
                  cursor_x_r   <= 7'd0;
                  first_char_r <= next_first_s;
                  wr_en_r      <= 1'b1;
                  wr_addr_r    <= first_char_r;
                  wr_data_r    <= SPACE;
                  clr_addr_r   <= first_char_r + 11'd1;
                  clr_cnt_r    <= 11'd1;
                  state_r      <= CLEAR_LINE;
               end
            end
            CLEAR_LINE: begin
               if (clr_cnt_r == ROW_LEN) begin
                  wr_en_r <= 1'b0;
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  wr_en_r    <= 1'b1;
                  wr_addr_r  <= clr_addr_r;
                  wr_data_r  <= SPACE;
                  clr_addr_r <= clr_addr_r + 11'd1;
                  clr_cnt_r  <= clr_cnt_r + 11'd1;
               end
            end
            default: begin
               wr_en_r   <= 1'b0;
               clr_cnt_r <= 11'd0;
               ready_r   <= 1'b0;
               state_r   <= CLEAR_ALL;
            end
         endcase
      end
   end

   // Cursor blink: vblank edge counter; an accepted byte takes priority and restarts the phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_r       <= 1'b1;
         blink_cnt_r   <= '0;
         vblank_prev_r <= 1'b0;
      end else begin
         vblank_prev_r <= vblank;
         if (accept_s) begin
            blink_r     <= 1'b1;
            blink_cnt_r <= '0;
         end else if (vblank_rise_s && (blink_cnt_r == BLINK_LAST)) begin
            blink_r     <= ~blink_r;
            blink_cnt_r <= '0;
         end else if (vblank_rise_s) begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
         end else begin
            blink_cnt_r <= blink_cnt_r;
         end
      end
   end

   assign char_ready      = ready_r;
   assign wr_en           = wr_en_r;
   assign wr_addr         = wr_addr_r;
   assign wr_data         = wr_data_r;
   assign cursor_x        = cursor_x_r;
   assign cursor_y        = cursor_y_r;
   assign first_char      = first_char_r;
   assign cursor_blink_on = blink_r;

endmodule
